nibble_serial_subtractor: RTL and testbench
===========================================

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand width in bits; legal values are multiples of 4 that are at least 4.
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operands valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: A  input  WIDTH  minuend.
REQ-007 SHALL have port: B  input  WIDTH  subtrahend.
REQ-008 SHALL have port: borrow_in  input  1  borrow into the LSB.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: diff  output  WIDTH  difference.
REQ-012 SHALL have port: borrow_out  output  1  borrow out of the MSB.
REQ-013 SHALL have port: overflow  output  1  signed two's-complement overflow.

Function
REQ-014 SHALL implement the FSM states IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL, in IDLE, capture A, B and borrow_in on an edge where in_valid is 1, then go to CALC with nibble index 0; otherwise it stays in IDLE.
REQ-016 SHALL, in CALC, compute one 4-bit nibble per cycle, LSB nibble first, using a borrow-lookahead slice: generate = ~a & b, propagate = ~(a ^ b), with the borrow chain computed in two-level form and no ripple inside the nibble.
REQ-017 SHALL register each nibble's borrow and feed it to the next nibble on the next cycle; the first nibble uses the captured borrow_in.
REQ-018 SHALL spend exactly N = WIDTH/4 cycles in CALC, then enter DONE. With the accept edge as edge 0, out_valid is first high after edge N (N=4 when WIDTH=16).
REQ-019 SHALL hold diff, borrow_out and overflow stable throughout DONE until an edge with out_ready=1, then return to IDLE.
REQ-020 SHALL NOT accept new operands in the same edge as the DONE-to-IDLE transition; the earliest next accept is one cycle later.
REQ-021 SHALL ignore in_valid in CALC and DONE, and leave captured operands unaffected by input changes after the accept edge.
REQ-022 SHALL compute diff = (A - B - borrow_in) mod 2^WIDTH.
REQ-023 SHALL set borrow_out = 1 iff unsigned A < B + borrow_in.
REQ-024 SHALL update diff nibbles progressively during CALC; their values are don't-care while out_valid=0.
REQ-025 SHALL, at the boundary A=B with borrow_in=1, give diff = all ones and borrow_out = 1.
REQ-026 SHALL wrap the nibble index from N-1 back to 0 on the transition to DONE.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state to IDLE, the nibble index to 0, the borrow register to 0, and diff, borrow_out, overflow and out_valid to 0; in_ready is therefore 1.
REQ-028 SHALL, on a reset asserted mid-CALC or in DONE, abandon the operation with no result presented; the first accept after rst_n rises starts a clean operation.

Configuration
REQ-029 SHALL, with macro SUB_OVERFLOW_EN defined, set overflow in DONE to (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]) using the captured operands.
REQ-030 SHALL, with SUB_OVERFLOW_EN undefined, tie overflow to 0 and synthesize no overflow logic; the port list is unchanged.

Verification (WIDTH=16)
REQ-031 SHALL cover: A=0x1234, B=0x0234, bin=0 -> diff=0x1000, borrow_out=0, overflow=0, out_valid high exactly 4 edges after accept.
REQ-032 SHALL cover: A=0x0000, B=0x0001, bin=0 -> diff=0xFFFF, borrow_out=1, overflow=0.
REQ-033 SHALL cover: A=0x8000, B=0x0001, bin=0 -> diff=0x7FFF, borrow_out=0, overflow=1 with SUB_OVERFLOW_EN and 0 without.
REQ-034 SHALL cover: A=0x0005, B=0x0005, bin=1 -> diff=0xFFFF, borrow_out=1.
REQ-035 SHALL cover: a result held with out_ready=0 for 3 cycles while in_valid=1 with new operands -> outputs unchanged, in_ready=0, no capture; then out_ready=1 -> IDLE, and the new operands are accepted one cycle later.
REQ-036 SHALL cover: rst_n pulsed low at CALC cycle 2 -> outputs 0 immediately (asynchronous), in_ready=1, and the next operation is correct.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : nibble_serial_subtractor
// Desc   : Serial A - B - borrow_in, one 4-bit borrow-lookahead nibble per
//          cycle. Define SUB_OVERFLOW_EN to enable the signed overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int c_NIB_CNT = WIDTH / 4;
  localparam int c_IDX_W   = (c_NIB_CNT > 1) ? $clog2(c_NIB_CNT) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NIB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_diff;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_borrow;
  logic                 r_borrow_out;
  logic [c_IDX_W+1:0]   w_base;
  logic [3:0]           w_a_nib;
  logic [3:0]           w_b_nib;
  logic [3:0]           w_g;
  logic [3:0]           w_p;
  logic [4:0]           w_bc;
  logic [3:0]           w_d_nib;
  logic                 w_last;

  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];
  assign w_last  = (r_idx == c_LAST_IDX);

  // Every internal borrow is a flat sum of products of g/p and the nibble carry-in.
  always_comb begin
    w_g     = ~w_a_nib & w_b_nib;
    w_p     = ~(w_a_nib ^ w_b_nib);
    w_bc[0] = r_borrow;
    w_bc[1] = w_g[0] | (w_p[0] & r_borrow);
    w_bc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    w_bc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
            | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    w_bc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
            | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
    w_d_nib = w_a_nib ^ w_b_nib ^ w_bc[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = CALC;
      CALC:    if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_idx        <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= borrow_in;
            r_idx    <= '0;
          end
        end
        CALC: begin
          r_diff[w_base +: 4] <= w_d_nib;
          r_borrow            <= w_bc[4];
          if (w_last) begin
            r_idx        <= '0;
            r_borrow_out <= w_bc[4];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

`ifdef SUB_OVERFLOW_EN
  logic r_overflow;

  // Final nibble's top bit is the result sign, so the flag settles on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (r_state == CALC && w_last) begin
      r_overflow <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_nib[3] != r_a[WIDTH-1]);
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : tb_nibble_serial_subtractor
// Desc   : Scoreboard bench for nibble_serial_subtractor (WIDTH=16).
// Rev    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_subtractor;

  localparam int c_W = 16;

  typedef struct packed {
    logic [c_W-1:0] d;
    logic           b;
    logic           o;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [c_W-1:0] A = '0;
  logic [c_W-1:0] B = '0;
  logic           borrow_in = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [c_W-1:0] diff;
  logic           borrow_out;
  logic           overflow;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  nibble_serial_subtractor #(.WIDTH(c_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                                 input logic bin);
    exp_t        m;
    logic [c_W:0] r;
    r   = {1'b0, a} - {1'b0, b} - {{c_W{1'b0}}, bin};
    m.d = r[c_W-1:0];
    m.b = r[c_W];
`ifdef SUB_OVERFLOW_EN
    m.o = (a[c_W-1] != b[c_W-1]) && (r[c_W-1] != a[c_W-1]);
`else
    m.o = 1'b0;
`endif
    return m;
  endfunction

  // Drives one operand set, pushes its expectation, and scrambles inputs after accept.
  task automatic start_op(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic bin);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    sb.push_back(model(a, b, bin));
    A = a; B = b; borrow_in = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, in_ready}, 32'd0);
    A = c_W'($urandom); B = c_W'($urandom); borrow_in = 1'($urandom);
  endtask

  task automatic wait_result();
    int lat = 0;
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) got = 1;
    end
    check("latency", lat, 4);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("diff", {16'd0, diff}, {16'd0, e.d});
      check("borrow_out", {31'd0, borrow_out}, {31'd0, e.b});
      check("overflow", {31'd0, overflow}, {31'd0, e.o});
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("released", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic bin);
    start_op(a, b, bin);
    wait_result();
    pop_check();
    release_result();
  endtask

  initial begin
    exp_t held;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {16'd0, diff}, 32'd0);
    check("rst_borrow_out", {31'd0, borrow_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op(c_W'($urandom), c_W'($urandom), 1'($urandom));

    // Result held under back-pressure while new operands are offered.
    start_op(16'hABCD, 16'h1111, 1'b1);
    wait_result();
    held = sb[0];
    A = 16'h4000; B = 16'hC000; borrow_in = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_diff", {16'd0, diff}, {16'd0, held.d});
      check("hold_borrow", {31'd0, borrow_out}, {31'd0, held.b});
    end
    pop_check();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after_release", {31'd0, in_ready}, 32'd1);
    check("no_valid_after_release", {31'd0, out_valid}, 32'd0);
    sb.push_back(model(16'h4000, 16'hC000, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("late_accept", {31'd0, in_ready}, 32'd0);
    wait_result();
    pop_check();
    release_result();

    // Asynchronous reset in the middle of CALC.
    start_op(16'h9876, 16'h1234, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_diff", {16'd0, diff}, 32'd0);
    check("arst_borrow_out", {31'd0, borrow_out}, 32'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0F0F, 16'h00FF, 1'b1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
